// File: rtl/rx_byte_fifo_if.sv
// Bundle of the receive-side and display-side signals around the byte FIFO.
// The master side is the producer/consumer logic. The slave side is the FIFO itself.
interface rx_byte_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [7:0]      Rx_Data;
  logic            Rx_Valid;
  logic            Pop;
  logic            Clear;
  logic [7:0]      Head_Data;
  logic            Empty;
  logic            Full;
  logic [ADDR_W:0] Count;
  logic            Overflow;
  logic [7:0]      Drop_Count;

  modport master (
    output Rx_Data, Rx_Valid, Pop, Clear,
    input  Head_Data, Empty, Full, Count, Overflow, Drop_Count
  );

  modport slave (
    input  Rx_Data, Rx_Valid, Pop, Clear,
    output Head_Data, Empty, Full, Count, Overflow, Drop_Count
  );
endinterface

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO between the UART receive path and the 7-segment display.
// The display always shows the oldest unread byte. A Pop pulse advances it.
// When the FIFO is full, received bytes are dropped.
// Each drop sets a sticky overflow flag and bumps a saturating drop counter.
module rx_byte_fifo #(
  parameter int DEPTH = 16
) (
  input logic           clk,
  input logic           rst,
  rx_byte_fifo_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic [7:0]        head_q, head_nxt;
  logic [7:0]        drop_q, drop_nxt;
  logic              ovf_q, ovf_nxt;
  logic              empty_q, full_q;
  logic              push_req, push_ok, pop_ok, drop;

  // Next-state decode. Clear wins over everything.
  // A pop at full frees the slot, so the same-cycle push still fits.
  // Head_Data is kept as a registered look-ahead of the byte at the new read pointer.
  always_comb begin
    push_req   = bus.Rx_Valid & ~bus.Clear;
    pop_ok     = bus.Pop & ~bus.Clear & (count_q != '0);
    push_ok    = push_req & ((count_q != CNT_DEPTH) | pop_ok);
    drop       = push_req & ~push_ok;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_q;
    head_nxt   = head_q;
    ovf_nxt    = ovf_q;
    drop_nxt   = drop_q;

    if (bus.Clear) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
      head_nxt   = 8'h00;
      ovf_nxt    = 1'b0;
      drop_nxt   = 8'h00;
    end else begin
      if (push_ok) begin
        wr_ptr_nxt = wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_nxt = rd_ptr + PTR_ONE;
      end

      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count_q + CNT_ONE;
        2'b01:   count_nxt = count_q - CNT_ONE;
        default: count_nxt = count_q;
      endcase

      if (count_nxt == '0) begin
        head_nxt = 8'h00;
      end else if (count_q == '0) begin
        head_nxt = bus.Rx_Data;
      end else if (pop_ok) begin
        if (count_q == CNT_ONE) begin
          head_nxt = bus.Rx_Data;
        end else begin
          head_nxt = mem[rd_ptr_nxt];
        end
      end

      if (drop) begin
        ovf_nxt = 1'b1;
        if (drop_q != 8'hFF) begin
          drop_nxt = drop_q + 8'h01;
        end
      end
    end
  end

  // Pointer, occupancy, head view and diagnostic flags.
  // Empty and Full are registered from the next occupancy value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= 8'h00;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      head_q  <= head_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CNT_DEPTH);
      ovf_q   <= ovf_nxt;
      drop_q  <= drop_nxt;
    end
  end

  // Byte storage.
  // It is never reset or cleared, because the pointers and the count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.Rx_Data;
    end
  end

  assign bus.Head_Data  = head_q;
  assign bus.Empty      = empty_q;
  assign bus.Full       = full_q;
  assign bus.Count      = count_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Drop_Count = drop_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo with DEPTH = 16.
// A queue holds the accepted bytes in arrival order.
// A monitor compares Head_Data against the oldest entry whenever a pop is issued.
module tb_rx_byte_fifo;

  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] sb_q [$];

  rx_byte_fifo_if #(.DEPTH(DEPTH)) bus ();

  rx_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: on each pop that should remove a byte, the displayed byte must be the oldest accepted one.
  initial begin
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk);
      if (!rst && bus.Pop && !bus.Clear && sb_q.size() > 0) begin
        exp_byte = sb_q.pop_front();
        checks++;
        if (bus.Head_Data !== exp_byte) begin
          errors++;
          $display("[TB] FAIL pop_head: got %h required %h", bus.Head_Data, exp_byte);
        end
      end
    end
  end

  // One cycle of input.
  // The expected byte is recorded after the edge so the monitor sees only bytes already stored.
  task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic p,
                                input logic c, input logic accept);
    bus.Rx_Valid = v;
    bus.Rx_Data  = d;
    bus.Pop      = p;
    bus.Clear    = c;
    @(posedge clk);
    #1;
    if (c) sb_q.delete();
    else if (v && accept) sb_q.push_back(d);
    bus.Rx_Valid = 1'b0;
    bus.Rx_Data  = 8'h00;
    bus.Pop      = 1'b0;
    bus.Clear    = 1'b0;
  endtask

  task automatic check_field(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_output(input string tag, input int cnt, input logic emp, input logic ful,
                              input logic ovf, input int drops, input int head);
    check_field({tag, ".count"},  int'(bus.Count), cnt);
    check_field({tag, ".empty"},  int'(bus.Empty), int'(emp));
    check_field({tag, ".full"},   int'(bus.Full), int'(ful));
    check_field({tag, ".ovf"},    int'(bus.Overflow), int'(ovf));
    check_field({tag, ".drops"},  int'(bus.Drop_Count), drops);
    check_field({tag, ".head"},   int'(bus.Head_Data), head);
  endtask

  // Directed sequence that follows the test plan.
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.Rx_Valid = 1'b0;
    bus.Rx_Data  = 8'h00;
    bus.Pop      = 1'b0;
    bus.Clear    = 1'b0;
    #12;
    check_output("reset", 0, 1, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single byte in, then out.
    apply_stimulus(1, 8'hA5, 0, 0, 1);
    check_output("push_a5", 1, 0, 0, 0, 0, 8'hA5);
    apply_stimulus(0, 8'h00, 1, 0, 1);
    check_output("pop_a5", 0, 1, 0, 0, 0, 8'h00);

    // Fill, overflow by one, then drain.
    for (int i = 0; i < 16; i++) apply_stimulus(1, 8'(i), 0, 0, 1);
    check_output("fill16", 16, 0, 1, 0, 0, 8'h00);
    apply_stimulus(1, 8'hFF, 0, 0, 0);
    check_output("overflow1", 16, 0, 1, 1, 1, 8'h00);
    for (int i = 0; i < 16; i++) apply_stimulus(0, 8'h00, 1, 0, 1);
    check_output("drain16", 0, 1, 0, 1, 1, 8'h00);

    // Clear the flags, fill, then push and pop together while full.
    apply_stimulus(0, 8'h00, 0, 1, 1);
    check_output("clear1", 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) apply_stimulus(1, 8'(8'h10 + i), 0, 0, 1);
    apply_stimulus(1, 8'h77, 1, 0, 1);
    check_output("full_push_pop", 16, 0, 1, 0, 0, 8'h11);
    for (int i = 0; i < 16; i++) apply_stimulus(0, 8'h00, 1, 0, 1);
    check_output("drain_77", 0, 1, 0, 0, 0, 8'h00);

    // Pop while empty, then pop together with a push into empty.
    apply_stimulus(0, 8'h00, 1, 0, 1);
    check_output("pop_empty", 0, 1, 0, 0, 0, 8'h00);
    apply_stimulus(1, 8'h3C, 1, 0, 1);
    check_output("push_pop_empty", 1, 0, 0, 0, 0, 8'h3C);
    apply_stimulus(0, 8'h00, 1, 0, 1);

    // Saturate the drop counter, then clear with a concurrent push.
    for (int i = 0; i < 16; i++) apply_stimulus(1, 8'(8'h40 + i), 0, 0, 1);
    for (int i = 0; i < 300; i++) apply_stimulus(1, 8'(i), 0, 0, 0);
    check_output("saturate", 16, 0, 1, 1, 8'hFF, 8'h40);
    apply_stimulus(1, 8'h99, 0, 1, 0);
    check_output("clear_push", 0, 1, 0, 0, 0, 8'h00);

    // Streaming push/pop so both pointers wrap twice.
    for (int i = 0; i < 40; i++) apply_stimulus(1, 8'(8'h80 + i), (i >= 3), 0, 1);
    check_output("stream", 3, 0, 0, 0, 0, 8'hA5);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check_output("async_rst", 0, 1, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("post_rst", 0, 1, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
# rx_byte_fifo

Buffers bytes produced by the UART receive path so that no received byte is lost while the user inspects the 7-segment display. Sits between the UART wrapper's receive output (Rx_Data plus a one-cycle done strobe) and the display wrapper: the display shows the oldest unread byte, and a debounced single-cycle Pop pulse advances to the next one. It also tracks overflow and counts dropped bytes for diagnostics.

## Interface
- DEPTH, 16, number of byte entries; power of two, 2..256
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- Rx_Data  in  8  received byte; sampled only when Rx_Valid=1
- Rx_Valid  in  1  one-cycle strobe: Rx_Data holds a new byte
- Pop  in  1  one-cycle pulse (from debounce/pulse stage): discard oldest byte
- Clear  in  1  one-cycle pulse: synchronous flush of contents and flags
- Head_Data  out  8  oldest stored byte; 8'h00 when Empty
- Empty  out  1  no bytes stored
- Full  out  1  Count == DEPTH
- Count  out  ADDR_W+1  number of stored bytes, 0..DEPTH
- Overflow  out  1  sticky: a byte was dropped since last Clear/reset
- Drop_Count  out  8  dropped-byte count, saturates at 8'hFF

## Operation
- Storage: DEPTH×8 array, write pointer wr_ptr, read pointer rd_ptr (ADDR_W bits, wrap modulo DEPTH), occupancy register Count.
- Push = Rx_Valid & ~Clear. Accepted if Count < DEPTH, or Count == DEPTH and Pop=1 same cycle. Accepted: mem[wr_ptr] <= Rx_Data, wr_ptr++.
- Rejected push (Full, no Pop): byte discarded, Overflow <= 1, Drop_Count++ unless already 8'hFF. Contents unchanged.
- Pop = Pop & ~Clear & (Count != 0). Pop while Empty is ignored, no flag.
- Count update: +1 push only, −1 pop only, unchanged for both or neither.
- Push and pop together at Count==0: pop ignored, push accepted, Count → 1.
- Push and pop together at Count==DEPTH: both accepted, Count stays DEPTH, no overflow.
- Clear has priority over everything: rd_ptr, wr_ptr, Count, Overflow, Drop_Count → 0; Head_Data → 8'h00; Rx_Valid and Pop that cycle are ignored. Array contents need not be cleared.
- Head_Data is a registered first-word-fall-through view: after each edge it equals the byte at the new rd_ptr, or 8'h00 if the new Count is 0. Push into empty loads Rx_Data directly into Head_Data.
- Empty and Full are registered, decoded from the next Count value (not combinational from Count).
- No state machine beyond the pointer/count registers; no internal clock enables.

## Timing
- Reset (asynchronous assert, synchronous release to clk): Head_Data=8'h00, Empty=1, Full=0, Count=0, Overflow=0, Drop_Count=0, both pointers 0. Reset mid-operation discards all stored bytes.
- Write latency: Rx_Valid at edge N → Count, Empty, and (if previously empty) Head_Data updated after edge N; visible during cycle N+1.
- Pop latency: Pop at edge N → Head_Data shows next byte (or 8'h00) during cycle N+1.
- Back-to-back Rx_Valid every cycle and Pop every cycle are sustained without bubbles.
- Overflow and Drop_Count update on the same edge as the rejected push.
- Pointer wrap: rd_ptr/wr_ptr roll DEPTH−1 → 0 with no effect on Count or flags.

## Test plan
- Reset then push 8'hA5 → next cycle Head_Data=8'hA5, Count=1, Empty=0; Pop → next cycle Head_Data=8'h00, Empty=1, Count=0.
- Push 16 bytes 8'h00..8'h0F (DEPTH=16) → Full=1, Count=16; push 8'hFF → Overflow=1, Drop_Count=1, Count=16; pop all 16 → Head_Data sequence 8'h00..8'h0F, no 8'hFF.
- Full FIFO, Rx_Valid=1 with Pop=1 same cycle (byte 8'h77) → Count stays 16, Overflow stays 0, 8'h77 emerges as 16th byte after 15 further pops.
- Empty FIFO, Pop alone → no change; Pop with push 8'h3C → Count=1, Head_Data=8'h3C.
- Push 300 bytes into a full FIFO without popping → Drop_Count=8'hFF (saturated), Overflow=1; Clear pulse with Rx_Valid=1 → all outputs at reset values next cycle, byte not stored.
- Interleave 40 pushes/pops to wrap pointers twice; assert rst asynchronously mid-stream → outputs at reset values immediately, FIFO order preserved throughout prior to reset.
